rojobot_lite: RTL and testbench

Cycle-based stand-in for the Rojobot simulator, the responder end of the bot register interface. It consumes the motor-control byte written by the PicoBlaze interface. It produces the location, bot-info and sensor registers, plus the `upd_sysregs` update pulse, which the interface turns into a PicoBlaze interrupt. It replaces the full simulator for fast regression and bring-up of the interface logic and firmware.

---
 rtl/rojobot_lite.sv | 185 ++++++++++++++++++
 tb/tb_rojobot_lite.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rojobot_lite.sv
// rojobot_lite: cycle-based stand-in for the Rojobot simulator.
// Builds pivot turning only when ROJOBOT_PIVOT_EN is defined.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   motctl[7:0]   {ldir, lspd[2:0], rdir, rspd[2:0]}, dir 1 = reverse
//   locX, locY    bot coordinates
//   botinfo       {1'b0, heading[2:0], movement[3:0]}
//   sensors       {3'b0, blocked, at_maxY, at_0Y, at_maxX, at_0X}
//   upd_sysregs   one-cycle pulse while freshly updated values are shown
module rojobot_lite #(
  parameter int UPDATE_DIV = 500000,
  parameter int MAX_X      = 127,
  parameter int MAX_Y      = 127,
  parameter int START_X    = 64,
  parameter int START_Y    = 64,
  parameter int START_HEAD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] motctl,
  output logic [7:0] locX,
  output logic [7:0] locY,
  output logic [7:0] botinfo,
  output logic [7:0] sensors,
  output logic       upd_sysregs
);

  localparam int CW = $clog2(UPDATE_DIV);
  localparam logic signed [9:0] MXS = 10'(MAX_X);
  localparam logic signed [9:0] MYS = 10'(MAX_Y);

  typedef enum logic [3:0] {
    MV_STOP = 4'd0,
    MV_FWD  = 4'd1,
    MV_REV  = 4'd2,
    MV_SPL  = 4'd3,
    MV_SPR  = 4'd4,
    MV_PVL  = 4'd5,
    MV_PVR  = 4'd6
  } mv_e;

  logic [7:0]       motctl_q;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [2:0]       head;
  logic [2:0]       head_n;
  mv_e              mv;
  mv_e              mv_q;
  logic [4:0]       sens_q;
  logic             lon, ron, lrev, rrev;
  logic             move;
  logic signed [9:0] dx, dy, nx, ny;
  logic [7:0]       x_n, y_n;
  logic             clx, cly;
  logic             phase;

  assign lon  = |motctl_q[6:4];
  assign ron  = |motctl_q[2:0];
  assign lrev = motctl_q[7];
  assign rrev = motctl_q[3];
  assign tick = (cnt == CW'(UPDATE_DIV - 1));

  always_comb begin
    mv = MV_STOP;
    unique case (1'b1)
      (!lon && !ron):                 mv = MV_STOP;
      (lon && ron && !lrev && !rrev): mv = MV_FWD;
      (lon && ron && lrev && rrev):   mv = MV_REV;
      (lon && ron && lrev && !rrev):  mv = MV_SPL;
      (lon && ron && !lrev && rrev):  mv = MV_SPR;
`ifdef ROJOBOT_PIVOT_EN
      (!lon && ron): mv = rrev ? MV_PVR : MV_PVL;
      (lon && !ron): mv = lrev ? MV_PVL : MV_PVR;
`else
      (lon ^ ron):   mv = MV_STOP;
`endif
    endcase
  end

  // pivots turn only on every second pivot tick
  always_comb begin
    head_n = head;
    case (mv)
      MV_SPL: head_n = head - 3'd1;
      MV_SPR: head_n = head + 3'd1;
      MV_PVL: if (phase) head_n = head - 3'd1;
      MV_PVR: if (phase) head_n = head + 3'd1;
      default: head_n = head;
    endcase
  end

  always_comb begin
    dx = '0;
    dy = '0;
    case (head)
      3'd0: dy = -10'sd1;
      3'd1: begin dx = 10'sd1;  dy = -10'sd1; end
      3'd2: dx = 10'sd1;
      3'd3: begin dx = 10'sd1;  dy = 10'sd1;  end
      3'd4: dy = 10'sd1;
      3'd5: begin dx = -10'sd1; dy = 10'sd1;  end
      3'd6: dx = -10'sd1;
      default: begin dx = -10'sd1; dy = -10'sd1; end
    endcase
    if (mv == MV_REV) begin
      dx = -dx;
      dy = -dy;
    end
  end

  assign move = (mv == MV_FWD) || (mv == MV_REV);
  assign nx   = $signed({2'b00, locX}) + dx;
  assign ny   = $signed({2'b00, locY}) + dy;

  // each axis saturates on its own at 0 and MAX
  always_comb begin
    x_n = locX;
    y_n = locY;
    clx = 1'b0;
    cly = 1'b0;
    if (move) begin
      if (nx < 10'sd0) begin
        x_n = 8'd0;
        clx = 1'b1;
      end else if (nx > MXS) begin
        x_n = 8'(MAX_X);
        clx = 1'b1;
      end else begin
        x_n = nx[7:0];
      end
      if (ny < 10'sd0) begin
        y_n = 8'd0;
        cly = 1'b1;
      end else if (ny > MYS) begin
        y_n = 8'(MAX_Y);
        cly = 1'b1;
      end else begin
        y_n = ny[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      motctl_q    <= 8'h00;
      cnt         <= '0;
      upd_sysregs <= 1'b0;
      locX        <= 8'(START_X);
      locY        <= 8'(START_Y);
      head        <= 3'(START_HEAD);
      mv_q        <= MV_STOP;
      sens_q      <= 5'd0;
    end else begin
      motctl_q    <= motctl;
      cnt         <= tick ? '0 : cnt + 1'b1;
      upd_sysregs <= tick;
      if (tick) begin
        locX   <= x_n;
        locY   <= y_n;
        head   <= head_n;
        mv_q   <= mv;
        sens_q <= {move && (clx || cly),
                   y_n == 8'(MAX_Y), y_n == 8'd0,
                   x_n == 8'(MAX_X), x_n == 8'd0};
      end
    end
  end

`ifdef ROJOBOT_PIVOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (tick) begin
      phase <= (mv == MV_PVL || mv == MV_PVR) ? ~phase : 1'b0;
    end
  end
`else
  assign phase = 1'b0;
`endif

  assign botinfo = {1'b0, head, mv_q};
  assign sensors = {3'b000, sens_q};

endmodule

// File: tb/tb_rojobot_lite.sv
// tb_rojobot_lite: random and directed checks of rojobot_lite
// against a tick-level behavioural model of the bot.
module tb_rojobot_lite;

  localparam int DIV = 4;

  typedef struct {
    int         x;
    int         y;
    int         h;
    int         mv;
    bit         ph;
    bit         blk;
    logic [7:0] sn;
  } bot_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] motctl1 = 8'h00;
  logic [7:0] motctl2 = 8'h00;
  logic [7:0] locx1, locy1, bi1, sn1;
  logic [7:0] locx2, locy2, bi2, sn2;
  logic       upd1, upd2;

  int   total = 0;
  int   bad = 0;
  int   k = 0;
  bot_t s1, s2, rst1, rst2;
  logic [7:0] q1, q2;

  always #5 clk = ~clk;

  rojobot_lite #(
    .UPDATE_DIV(DIV), .MAX_X(127), .MAX_Y(127),
    .START_X(64), .START_Y(64), .START_HEAD(0)
  ) dut1 (
    .clk(clk), .reset(reset), .motctl(motctl1),
    .locX(locx1), .locY(locy1), .botinfo(bi1),
    .sensors(sn1), .upd_sysregs(upd1)
  );

  rojobot_lite #(
    .UPDATE_DIV(DIV), .MAX_X(127), .MAX_Y(127),
    .START_X(126), .START_Y(1), .START_HEAD(2)
  ) dut2 (
    .clk(clk), .reset(reset), .motctl(motctl2),
    .locX(locx2), .locY(locy2), .botinfo(bi2),
    .sensors(sn2), .upd_sysregs(upd2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int mx,
                                inout bit hit);
    if (v < 0) begin
      hit = 1;
      return 0;
    end
    if (v > mx) begin
      hit = 1;
      return mx;
    end
    return v;
  endfunction

  // one update of the bot from the motor byte it acts on
  function automatic bot_t mdl(input bot_t s,
                               input logic [7:0] m,
                               input int mx, input int my);
    bot_t n = s;
    bit lon = (m[6:4] != 0);
    bit ron = (m[2:0] != 0);
    int turn = 0;
    int step = 0;
    bit piv = 0;
    bit hit = 0;
    int dx, dy;
    n.mv = 0;
    if (lon && ron) begin
      if (m[7] == m[3]) begin
        step = m[7] ? -1 : 1;
        n.mv = m[7] ? 2 : 1;
      end else begin
        turn = m[7] ? -1 : 1;
        n.mv = m[7] ? 3 : 4;
      end
    end else if (lon || ron) begin
`ifdef ROJOBOT_PIVOT_EN
      bit left = ron ? !m[3] : m[7];
      piv = 1;
      n.mv = left ? 5 : 6;
      if (s.ph) turn = left ? -1 : 1;
`endif
    end
    n.ph = piv ? !s.ph : 0;
    n.h = (s.h + turn + 8) % 8;
    if (step != 0) begin
      dx = (n.h >= 1 && n.h <= 3) ? 1 :
           (n.h >= 5) ? -1 : 0;
      dy = (n.h == 7 || n.h <= 1) ? -1 :
           (n.h >= 3 && n.h <= 5) ? 1 : 0;
      n.x = clampv(s.x + step * dx, mx, hit);
      n.y = clampv(s.y + step * dy, my, hit);
    end
    n.blk = hit;
    n.sn = {3'b000, hit, n.y == my, n.y == 0,
            n.x == mx, n.x == 0};
    return n;
  endfunction

  function automatic logic [7:0] binfo(input bot_t s);
    return {1'b0, 3'(s.h), 4'(s.mv)};
  endfunction

  task automatic cyc(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic r);
    logic t;
    t = 1'b0;
    motctl1 = a;
    motctl2 = b;
    reset = r;
    @(posedge clk);
    if (r) begin
      s1 = rst1;
      s2 = rst2;
      q1 = 8'h00;
      q2 = 8'h00;
      k = 0;
    end else begin
      k++;
      t = ((k % DIV) == 0);
      if (t) begin
        s1 = mdl(s1, q1, 127, 127);
        s2 = mdl(s2, q2, 127, 127);
      end
      q1 = a;
      q2 = b;
    end
    #1;
    chk("upd1", 32'(upd1), 32'(t));
    chk("x1", 32'(locx1), 32'(s1.x));
    chk("y1", 32'(locy1), 32'(s1.y));
    chk("bi1", 32'(bi1), 32'(binfo(s1)));
    chk("sn1", 32'(sn1), 32'(s1.sn));
    chk("upd2", 32'(upd2), 32'(t));
    chk("x2", 32'(locx2), 32'(s2.x));
    chk("y2", 32'(locy2), 32'(s2.y));
    chk("bi2", 32'(bi2), 32'(binfo(s2)));
    chk("sn2", 32'(sn2), 32'(s2.sn));
  endtask

  initial begin
    int pulses;
    int first;
    logic [7:0] r1, r2;
    logic [7:0] piv_bi [4];
    rst1 = '{x:64, y:64, h:0, mv:0, ph:0, blk:0, sn:8'h00};
    rst2 = '{x:126, y:1, h:2, mv:0, ph:0, blk:0, sn:8'h00};
    s1 = rst1;
    s2 = rst2;
    q1 = 8'h00;
    q2 = 8'h00;
`ifdef ROJOBOT_PIVOT_EN
    piv_bi = '{8'h65, 8'h55, 8'h55, 8'h45};
`else
    piv_bi = '{8'h60, 8'h60, 8'h60, 8'h60};
`endif

    cyc(8'h00, 8'h00, 1'b1);
    cyc(8'h00, 8'h00, 1'b1);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(8'h00, 8'h00, 1'b0);
      if (upd1) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd3);
    chk("idle_xy", 32'({locx1, locy1}), 32'h4040);
    chk("idle_bi", 32'(bi1), 32'h00);
    chk("idle_sn", 32'(sn1), 32'h00);

    for (int i = 0; i < 12; i++) begin
      cyc(8'h11, 8'h11, 1'b0);
      if (i % 4 == 3) begin
        chk("fwd_y", 32'(locy1), 32'(63 - i / 4));
        chk("fwd_x", 32'(locx1), 32'd64);
        chk("fwd_bi", 32'(bi1), 32'h01);
        chk("east_x", 32'(locx2), 32'd127);
        chk("east_sn", 32'(sn2), (i < 4) ? 32'h02 : 32'h12);
      end
    end

    for (int i = 0; i < 8; i++) begin
      cyc(8'h91, 8'h00, 1'b0);
      if (i == 3) begin
        chk("spin_bi0", 32'(bi1), 32'h73);
        chk("stop_sn", 32'(sn2), 32'h02);
      end
    end
    chk("spin_bi1", 32'(bi1), 32'h63);

    for (int i = 0; i < 4; i++) cyc(8'h11, 8'h00, 1'b0);
    chk("west_x", 32'(locx1), 32'd63);
    chk("west_y", 32'(locy1), 32'd61);
    chk("west_bi", 32'(bi1), 32'h61);

    for (int i = 0; i < 16; i++) begin
      cyc(8'h01, 8'h00, 1'b0);
      if (i % 4 == 3) chk("piv_bi", 32'(bi1), 32'(piv_bi[i / 4]));
    end

    for (int i = 0; i < 6; i++) cyc(8'h11, 8'h11, 1'b0);
    cyc(8'h11, 8'h11, 1'b1);
    chk("rst_xy", 32'({locx1, locy1}), 32'h4040);
    chk("rst_bi", 32'(bi1), 32'h00);
    chk("rst_upd", 32'(upd1), 32'd0);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(8'h00, 8'h00, 1'b0);
      if (upd1 && first == 0) first = i;
    end
    chk("rst_gap", 32'(first), 32'(DIV));

    r1 = 8'h00;
    r2 = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) r1 = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r2 = 8'($urandom);
      cyc(r1, r2, ($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
